// File: rtl/bus_pkg.sv
// bus_pkg: region/state types, decode constants and the address decode helper
// shared by the 68000 bus controller.
package bus_pkg;
   typedef enum logic [2:0] {
      REG_ROM, REG_RAM, REG_DUART, REG_EXP, REG_LED, REG_UNMAPPED, REG_IACK
   } region_t;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_t;
   localparam logic [3:0] NIB_ROM = 4'h0;
   localparam logic [3:0] NIB_RAM = 4'h8;
   localparam logic [3:0] NIB_DUART = 4'hC;
   localparam logic [3:0] NIB_EXP = 4'hD;
   localparam logic [3:0] NIB_LED = 4'hF;
   localparam logic [2:0] FC_CPU_SPACE = 3'b111;
   // hi = A23..A16; a CPU-space cycle with A19..A16 all ones is an interrupt acknowledge
   function automatic region_t decode(input logic [7:0] hi, input logic [2:0] fc);
      return (fc == FC_CPU_SPACE && hi[3:0] == 4'hF) ? REG_IACK :
             hi[7:4] == NIB_ROM         ? REG_ROM :
             hi[7:6] == NIB_RAM[3:2]    ? REG_RAM :
             hi[7:4] == NIB_DUART       ? REG_DUART :
             hi[7:4] == NIB_EXP         ? REG_EXP :
             hi[7:4] == NIB_LED         ? REG_LED : REG_UNMAPPED;
   endfunction
endpackage

// File: rtl/bus_controller_irq_encoder.sv
// irq_encoder: synchronises active-low interrupt requests and registers the
// active-low encoding of the highest pending level.
module irq_encoder #(
   parameter int NUM_IRQ = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   output logic [2:0]         ipl
);
   logic [NUM_IRQ-1:0] s1, s2;
   logic [2:0] lvl;
   always_comb begin
      lvl = '0;
      for (int i = 0; i < NUM_IRQ; i++) if (!s2[i]) lvl = 3'(i + 1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '1;
         s2 <= '1;
         ipl <= 3'b111;
      end else begin
         s1 <= irq;
         s2 <= s1;
         ipl <= ~lvl;
      end
   end
endmodule

// File: rtl/bus_controller.sv
// bus_controller: 68000 glue logic - clock divider, boot overlay, chip selects,
// wait-state DTACK, expansion DTACK, bus-error watchdog and interrupt handling.
module bus_controller
   import bus_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int ROM_WAIT = 2,
   parameter int RAM_WAIT = 0,
   parameter int IO_WAIT = 4,
   parameter int BERR_TIMEOUT = 256,
   parameter int BOOT_CYCLES = 4,
   parameter int NUM_IRQ = 7,
   parameter int DUART_LEVEL = 5,
   parameter int LED_WIDTH = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic                 CLK_CPU,
   input  logic [9:0]           ADDR_H,
   input  logic [3:0]           ADDR_L,
   input  logic                 AS,
   input  logic                 UDS,
   input  logic                 LDS,
   input  logic                 RW,
   input  logic [2:0]           FC,
   input  logic [7:0]           DATA,
   input  logic                 EXP_DTACK,
   input  logic [NUM_IRQ-1:0]   IRQ,
   output logic [2:0]           IPL,
   output logic                 DTACK,
   output logic                 BERR,
   output logic                 VPA,
   output logic                 ROM_LOWER,
   output logic                 ROM_UPPER,
   output logic                 RAM_LOWER,
   output logic                 RAM_UPPER,
   output logic                 DUART,
   output logic                 EXP,
   output logic                 IACK_DUART,
   output logic [LED_WIDTH-1:0] LED
);
   localparam int HALF = CLK_DIV / 2;
   localparam int WMAX = ROM_WAIT > RAM_WAIT ? (ROM_WAIT > IO_WAIT ? ROM_WAIT : IO_WAIT)
                                             : (RAM_WAIT > IO_WAIT ? RAM_WAIT : IO_WAIT);
   localparam int WW = WMAX > 0 ? $clog2(WMAX + 1) : 1;
   localparam int DW = $clog2(HALF + 1);
   localparam int TW = $clog2(BERR_TIMEOUT + 1);
   localparam int BW = $clog2(BOOT_CYCLES + 1);
   logic [DW-1:0] div_cnt;
   logic as_r, as_d, rw_r;
   logic [2:0] fc_r;
   logic [1:0] exp_sync;
   logic [BW-1:0] boot_cnt;
   logic [WW-1:0] wcnt, wload;
   logic [TW-1:0] wd;
   logic [2:0] lvl_q;
   logic boot, sel, done, duart_lvl, unused;
   region_t dec, region, region_q;
   state_t state;
   assign unused = ^{ADDR_H[1:0], ADDR_L[0], DATA};
   assign boot = boot_cnt != BW'(BOOT_CYCLES);
   assign dec = decode(ADDR_H[9:2], fc_r);
   assign region = (boot && dec != REG_IACK) ? REG_ROM : dec;
   // selects follow the raw strobes so memories see them without a clock of delay
   assign sel = RST && !AS;
   assign ROM_LOWER = !(sel && !LDS && region == REG_ROM);
   assign ROM_UPPER = !(sel && !UDS && region == REG_ROM);
   assign RAM_LOWER = !(sel && !LDS && region == REG_RAM);
   assign RAM_UPPER = !(sel && !UDS && region == REG_RAM);
   assign DUART = !(sel && !LDS && region == REG_DUART);
   assign EXP = !(sel && !(LDS && UDS) && region == REG_EXP);
   assign wload = region == REG_ROM ? WW'(ROM_WAIT) : region == REG_RAM ? WW'(RAM_WAIT) : WW'(IO_WAIT);
   assign done = region_q == REG_EXP ? !exp_sync[1] : (region_q != REG_UNMAPPED && wcnt == '0);
   assign duart_lvl = lvl_q == 3'(DUART_LEVEL);
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div_cnt <= '0;
         CLK_CPU <= 1'b0;
         as_r <= 1'b1;
         as_d <= 1'b1;
         rw_r <= 1'b1;
         fc_r <= '0;
         exp_sync <= 2'b11;
         boot_cnt <= '0;
      end else begin
         div_cnt <= div_cnt == DW'(HALF - 1) ? '0 : div_cnt + 1'b1;
         if (div_cnt == DW'(HALF - 1)) CLK_CPU <= !CLK_CPU;
         as_r <= AS;
         as_d <= as_r;
         rw_r <= RW;
         fc_r <= FC;
         exp_sync <= {exp_sync[0], EXP_DTACK};
         if (as_r && !as_d && boot) boot_cnt <= boot_cnt + 1'b1;
      end
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
         region_q <= REG_ROM;
         lvl_q <= '0;
         wcnt <= '0;
         wd <= '0;
         DTACK <= 1'b1;
         BERR <= 1'b1;
         VPA <= 1'b1;
         IACK_DUART <= 1'b1;
         LED <= '0;
      end else begin
         case (state)
            ST_IDLE: if (!as_r) begin
               state <= ST_WAIT;
               region_q <= region;
               lvl_q <= ADDR_L[3:1];
               wcnt <= wload;
               wd <= '0;
            end
            ST_WAIT: if (done) begin
               state <= ST_ACK;
               DTACK <= region_q == REG_IACK && !duart_lvl;
               VPA <= !(region_q == REG_IACK && !duart_lvl);
               IACK_DUART <= !(region_q == REG_IACK && duart_lvl);
               if (region_q == REG_LED && !rw_r) LED <= DATA[LED_WIDTH-1:0];
            end else if (wd == TW'(BERR_TIMEOUT - 1)) begin
               state <= ST_ERR;
               BERR <= 1'b0;
            end else begin
               if (wcnt != '0) wcnt <= wcnt - 1'b1;
               wd <= wd + 1'b1;
            end
            default: if (as_r) begin
               state <= ST_IDLE;
               DTACK <= 1'b1;
               BERR <= 1'b1;
               VPA <= 1'b1;
               IACK_DUART <= 1'b1;
            end
         endcase
      end
   end
   irq_encoder #(.NUM_IRQ(NUM_IRQ)) u_irq (.clk(CLK), .rst_n(RST), .irq(IRQ), .ipl(IPL));
endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Parametrised successor to the board's glue-logic controller, sitting between the 68000 and the ROM, RAM, DUART and expansion decode.
- Adds the following over the fixed-DTACK design: CPU clock divider, boot-vector ROM overlay, per-region wait-state DTACK generation, expansion DTACK pass-through, bus-error watchdog, interrupt priority encoder and IACK/autovector handling.
- All logic runs on CLK.

Parameters:
- CLK_DIV, 2: CLK cycles per CLK_CPU period; even, at least 2.
- ROM_WAIT, 2: CLK cycles from AS sampled low to DTACK for ROM.
- RAM_WAIT, 0: same, for RAM.
- IO_WAIT, 4: same, for DUART and LED.
- BERR_TIMEOUT, 256: CLK cycles without termination before BERR is asserted.
- BOOT_CYCLES, 4: number of bus cycles after reset during which the ROM overlay is active.
- NUM_IRQ, 7: number of interrupt inputs, 1 to 7.
- DUART_LEVEL, 5: interrupt level acknowledged by the DUART; all other levels are autovectored.
- LED_WIDTH, 3: width of the LED register.

Ports:
- CLK in 1: system clock.
- RST in 1: asynchronous reset, active-low.
- CLK_CPU out 1: divided CPU clock.
- ADDR_H in 10: A23..A14.
- ADDR_L in 4: A4..A1.
- AS, UDS, LDS in 1 each: bus strobes, active-low.
- RW in 1: 1 = read.
- FC in 3: function code.
- DATA in 8: D7..D0.
- EXP_DTACK in 1: expansion-card acknowledge, active-low.
- IRQ in NUM_IRQ: IRQ[i] requests level i+1, active-low.
- IPL out 3: encoded interrupt level, active-low.
- DTACK, BERR, VPA out 1 each: bus termination outputs, active-low.
- ROM_LOWER, ROM_UPPER, RAM_LOWER, RAM_UPPER, DUART, EXP out 1 each: chip selects, active-low.
- IACK_DUART out 1: DUART interrupt acknowledge, active-low.
- LED out LED_WIDTH: LED register.

Behaviour:
- Reset (RST low, asynchronous):
  - CLK_CPU=0; DTACK, BERR, VPA, IACK_DUART=1; all chip selects=1; IPL=3'b111; LED=0.
  - Divider, timers and boot counter cleared; boot=1; FSM=IDLE.
  - Asserting reset mid-cycle aborts the cycle immediately.
- Clock divider: CLK_CPU toggles every CLK_DIV/2 CLK cycles and is registered, so it is glitch-free.
- Input sampling: AS, UDS, LDS, RW and FC are registered once on CLK. IRQ and EXP_DTACK pass through 2-flop synchronisers.
- Decode uses A23..A20:
  - ROM: 0x0-.
  - RAM: 0x8- through 0xB-.
  - DUART: 0xC-.
  - EXP: 0xD-.
  - LED: 0xF-.
  - Unmapped: everything else.
  - IACK: FC=111 with A19..A16=1111. IACK takes precedence over the address decode.
- Boot overlay: while boot=1, every non-IACK cycle decodes as ROM. Each AS rising edge increments the boot counter; boot clears when the count reaches BOOT_CYCLES and stays clear until the next reset.
- Chip selects (combinational): active only while AS is low and the matching region is decoded.
  - Lower selects also require LDS low; upper selects require UDS low.
  - DUART requires LDS low.
  - EXP is active on either strobe.
  - All chip selects are forced to 1 during reset.
- Termination FSM (IDLE, WAIT, ACK, ERR):
  - IDLE→WAIT when registered AS is low. Load the wait counter with the region's wait value: ROM_WAIT, RAM_WAIT, or IO_WAIT for DUART, LED and IACK. Clear the watchdog.
  - WAIT→ACK when the counter reaches 0. For EXP, instead wait for synchronised EXP_DTACK low. Unmapped cycles never reach ACK.
  - WAIT→ERR when the watchdog reaches BERR_TIMEOUT-1 with no termination.
  - ACK: one output is asserted:
    - DTACK for memory, DUART, LED and EXP cycles.
    - DTACK plus IACK_DUART for an IACK whose ADDR_L[3:1] equals DUART_LEVEL.
    - VPA for any other IACK level.
  - ERR: BERR asserted.
  - ACK or ERR→IDLE when registered AS returns high; outputs are released on that same edge.
  - A zero wait value still takes one WAIT cycle, so minimum latency is 2 CLK from AS sampled low.
- LED: on entry to ACK for an LED-region cycle with RW=0, LED <= DATA[LED_WIDTH-1:0]. Reads do not change LED.
- Interrupt encoder:
  - Registered each CLK: level = highest i+1 with synchronised IRQ[i] low; IPL = ~level.
  - No request gives IPL=111.
  - Simultaneous requests resolve to the highest level.
- Widths: counters are sized with $clog2 of their maximum value plus 1, and saturate; the watchdog never wraps.

Decomposition:
- Shared package bus_pkg holds:
  - Region enum: REG_ROM, REG_RAM, REG_DUART, REG_EXP, REG_LED, REG_UNMAPPED, REG_IACK.
  - FSM state enum.
  - Region base nibble constants.
  - FC_CPU_SPACE constant.
- One sub-module, irq_encoder (synchroniser plus priority encoder, parametrised by NUM_IRQ).
- Address decode and termination FSM stay in bus_controller.

Test Plan:
- Reset, then the first 4 reads at 0xF00000 → ROM_LOWER and ROM_UPPER low (overlay), DTACK after ROM_WAIT+1 CLK. The 5th read at 0xF00000 → no ROM select.
- Word write of 0x0005 to 0xF00000, RW=0 → DTACK low after IO_WAIT+1 CLK; LED=3'b101 after ACK; DTACK high one CLK after AS rises.
- Read at 0x400000 (unmapped), AS held low → no DTACK; BERR low at cycle BERR_TIMEOUT; BERR released when AS goes high.
- IRQ[4] and IRQ[1] low together → IPL=~3'd5 after 3 CLK. IACK with FC=111 and ADDR_L[3:1]=5 → IACK_DUART and DTACK low. IACK at level 2 → VPA low, DTACK high.
- EXP read at 0xD00000 with EXP_DTACK asserted 10 CLK later → EXP low throughout; DTACK low 2 CLK after EXP_DTACK falls.
- RST pulsed low during the WAIT of a RAM cycle → all outputs at reset values immediately, boot=1 again, LED=0.
